// File: rtl/bin_pool_framer.sv
`default_nettype none
// ============================================================================
// Module   : bin_pool_framer
// Purpose  : KxK max/min pooling of a binary pixel stream into a framed output.
//            Optional frame/drop statistics with BIN_POOL_FRAMER_STATS_EN.
// Revision : 1.0
// ============================================================================
module bin_pool_framer #(
    parameter int IMG_W     = 224,
    parameter int IMG_H     = 224,
    parameter int POOL_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_data,
    input  logic        in_sof,
    input  logic        pool_mode,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        out_data,
    output logic        out_last,
    output logic        busy,
    output logic        frame_err,
    output logic        frame_drop
`ifdef BIN_POOL_FRAMER_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int K     = 1 << POOL_LOG2;
    localparam int OUT_W = IMG_W / K;
    localparam int OUT_H = IMG_H / K;
    localparam int OUT_N = OUT_W * OUT_H;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int BW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(OUT_N - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_READOUT = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [BW-1:0]    r_rd_idx;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_N-1:0] r_buf;
    logic             r_mode;

    logic          w_sof_take, w_take, w_mode, w_first, w_blk_last, w_last_px;
    logic          w_fold, w_xfer, w_rd_last, w_err_evt, w_drop_evt;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [AW-1:0] w_bcol;
    logic [BW-1:0] w_addr;

    // A sof accepted in IDLE or CAPTURE makes the current pixel (0,0) of a new frame.
    assign w_sof_take = in_valid & in_sof & ((r_state == S_IDLE) | (r_state == S_CAPTURE));
    assign w_take     = in_valid & ((r_state == S_CAPTURE) | ((r_state == S_IDLE) & in_sof));
    assign w_col      = w_sof_take ? '0 : r_col;
    assign w_row      = w_sof_take ? '0 : r_row;
    assign w_mode     = w_sof_take ? pool_mode : r_mode;
    assign w_bcol     = AW'(w_col >> POOL_LOG2);
    assign w_first    = ((int'(w_col) % K) == 0) && ((int'(w_row) % K) == 0);
    assign w_blk_last = ((int'(w_col) % K) == K - 1) && ((int'(w_row) % K) == K - 1);
    assign w_last_px  = (w_col == COL_LAST) && (w_row == ROW_LAST);
    assign w_addr     = BW'((int'(w_row) / K) * OUT_W + int'(w_col) / K);
    assign w_fold     = w_first ? in_data
                      : (w_mode ? (r_acc[w_bcol] & in_data) : (r_acc[w_bcol] | in_data));

    assign w_xfer     = (r_state == S_READOUT) & out_ready;
    assign w_rd_last  = (r_rd_idx == IDX_LAST);
    assign w_err_evt  = (r_state == S_CAPTURE) & in_valid & in_sof & ((r_col != '0) | (r_row != '0));
    assign w_drop_evt = (r_state == S_READOUT) & in_valid & in_sof;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_next = w_last_px ? S_READOUT : S_CAPTURE;
            S_CAPTURE: if (w_take && w_last_px) w_next = S_READOUT;
            S_READOUT: if (w_xfer && w_rd_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_READOUT);
        out_data  = out_valid & r_buf[r_rd_idx];
        out_last  = out_valid & w_rd_last;
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rd_idx   <= '0;
            r_acc      <= '0;
            r_mode     <= 1'b0;
            frame_err  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_err  <= w_err_evt;
            frame_drop <= w_drop_evt;
            if (w_take) begin
                r_acc[w_bcol] <= w_fold;
                r_mode        <= w_mode;
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
            if (w_xfer) begin
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
            end
        end
    end

    // Frame buffer keeps its contents across reset; only the read pointer is cleared.
    always_ff @(posedge clk) begin
        if (w_take && w_blk_last) begin
            r_buf[w_addr] <= w_fold;
        end
    end

`ifdef BIN_POOL_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (w_xfer && w_rd_last && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((w_err_evt || w_drop_evt) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_pool_framer.sv
`default_nettype none
// Testbench for bin_pool_framer with an 8x8 frame pooled 2x2 into 16 outputs.
module tb_bin_pool_framer;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_data, in_sof, pool_mode, out_ready;
    logic out_valid, out_data, out_last, busy, frame_err, frame_drop;
`ifdef BIN_POOL_FRAMER_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    int n_drop = 0;
    int exp_frames = 0;
    int exp_drops  = 0;

    always #5 clk = ~clk;

    bin_pool_framer #(.IMG_W(8), .IMG_H(8), .POOL_LOG2(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .pool_mode  (pool_mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_err  (frame_err),
        .frame_drop (frame_drop)
`ifdef BIN_POOL_FRAMER_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    // Pulse monitors: a count of high cycles also catches pulses wider than one cycle.
    always @(negedge clk) begin
        if (frame_err)  n_err  <= n_err + 1;
        if (frame_drop) n_drop <= n_drop + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each output is the OR (mode 0) or AND (mode 1) of its 2x2 block.
    function automatic logic [15:0] model(input logic [63:0] img, input logic mode);
        logic [15:0] r;
        logic v;
        r = '0;
        for (int by = 0; by < 4; by++) begin
            for (int bx = 0; bx < 4; bx++) begin
                v = mode;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        if (mode) v = v & img[(2*by+dy)*8 + 2*bx+dx];
                        else      v = v | img[(2*by+dy)*8 + 2*bx+dx];
                    end
                end
                r[by*4+bx] = v;
            end
        end
        return r;
    endfunction

    task automatic feed(input logic [63:0] img, input logic mode, input bit gaps, input int npx);
        for (int p = 0; p < npx; p++) begin
            if (gaps && p > 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid  = 1'b0;
                in_sof    = 1'($urandom);
                in_data   = 1'($urandom);
                pool_mode = 1'($urandom);
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_sof    = (p == 0);
            in_data   = img[p];
            pool_mode = (p == 0) ? mode : 1'($urandom);
            out_ready = 1'($urandom);
        end
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. drop_at/rst_at < 0 disable.
    task automatic readout(input logic [15:0] exp, input int rmode, input int drop_at, input int rst_at);
        int  cnt;
        int  cyc;
        logic rdy;
        cnt = 0;
        cyc = 0;
        while (cnt < 16 && cyc < 200) begin
            @(negedge clk);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom);
            endcase
            if (drop_at >= 0 && cyc >= drop_at) begin
                in_valid = 1'b1;
                in_sof   = (cyc == drop_at);
                in_data  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'($urandom);
            end
            if (cyc == 0) chk("busy_in_readout", busy, 1);
            chk("out_valid", out_valid, 1);
            if (out_valid) begin
                chk("out_data", out_data, exp[cnt]);
                chk("out_last", out_last, (cnt == 15));
                if (rst_at == cnt) begin
                    rst_n     = 1'b0;
                    out_ready = rdy;
                    @(negedge clk);
                    rst_n    = 1'b1;
                    in_valid = 1'b0;
                    chk("valid_after_rst", out_valid, 0);
                    chk("busy_after_rst", busy, 0);
                    chk("last_after_rst", out_last, 0);
                    exp_frames = 0;
                    exp_drops  = 0;
                    return;
                end
                if (rdy) cnt++;
            end
            out_ready = rdy;
            cyc++;
        end
        if (cnt < 16) chk("readout_timeout", cnt, 16);
        else exp_frames++;
        @(negedge clk);
        in_sof    = 1'b0;
        in_valid  = (drop_at >= 0);
        out_ready = 1'($urandom);
        chk("valid_after_frame", out_valid, 0);
        chk("busy_after_frame", busy, 0);
    endtask

    typedef struct {
        logic [63:0] img;
        logic        mode;
        int          rmode;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] img_a, img_b;
        logic        m;
        int          e0, d0;

        vecs[0] = '{64'h1 << 43,            1'b0, 0, 16'h0200};
        vecs[1] = '{~64'h1,                 1'b1, 0, 16'hFFFE};
        vecs[2] = '{64'h1 << 43,            1'b0, 1, 16'h0200};
        vecs[3] = '{64'h0,                  1'b0, 1, 16'h0000};
        vecs[4] = '{~64'h0,                 1'b1, 2, 16'hFFFF};
        vecs[5] = '{64'h303,                1'b1, 0, 16'h0001};
        vecs[6] = '{64'h003,                1'b1, 1, 16'h0000};
        vecs[7] = '{64'h003,                1'b0, 2, 16'h0001};
        vecs[8] = '{64'h1 << 63,            1'b0, 0, 16'h8000};
        vecs[9] = '{~(64'h1 << 63),         1'b1, 0, 16'h7FFF};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_sof = 1'b0;
        pool_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_drop", frame_drop, 0);
`ifdef BIN_POOL_FRAMER_STATS_EN
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        rst_n = 1'b1;

        // Pixels without sof while idle must be ignored.
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1; in_sof = 1'b0; in_data = 1'($urandom);
            chk("idle_ignore", busy, 0);
        end

        for (int i = 0; i < 10; i++) begin
            feed(vecs[i].img, vecs[i].mode, 1'b0, 64);
            readout(vecs[i].exp, vecs[i].rmode, -1, -1);
        end

        // Restart by sof at pixel 20: only frame B, in its own mode, is output.
        e0 = n_err;
        img_a = {$urandom, $urandom};
        img_b = {$urandom, $urandom};
        feed(img_a, 1'b0, 1'b0, 20);
        feed(img_b, 1'b1, 1'b0, 64);
        readout(model(img_b, 1'b1), 0, -1, -1);
        chk("frame_err_pulses", n_err - e0, 1);
        exp_drops++;

        // Sof during readout: current frame completes, the dropped frame never appears.
        d0 = n_drop;
        img_a = {$urandom, $urandom};
        feed(img_a, 1'b0, 1'b0, 64);
        readout(model(img_a, 1'b0), 0, 3, -1);
        chk("frame_drop_pulses", n_drop - d0, 1);
        exp_drops++;
        repeat (50) begin
            @(negedge clk);
            in_valid = 1'b1; in_sof = 1'b0; in_data = 1'($urandom);
            chk("dropped_frame_ignored", busy, 0);
        end
`ifdef BIN_POOL_FRAMER_STATS_EN
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("drop_cnt", drop_cnt, exp_drops);
`endif
        img_b = {$urandom, $urandom};
        feed(img_b, 1'b1, 1'b0, 64);
        readout(model(img_b, 1'b1), 2, -1, -1);

        // Reset at readout index 7, then a fresh frame reads from index 0.
        img_a = {$urandom, $urandom};
        feed(img_a, 1'b0, 1'b0, 64);
        readout(model(img_a, 1'b0), 0, -1, 7);
        img_b = {$urandom, $urandom};
        feed(img_b, 1'b0, 1'b0, 64);
        readout(model(img_b, 1'b0), 0, -1, -1);

        for (int i = 0; i < 6; i++) begin
            img_a = {$urandom, $urandom};
            if (i == 0) img_a = img_a | 64'hFFFF_0000_0000_0000;
            m = 1'($urandom);
            feed(img_a, m, 1'b1, 64);
            readout(model(img_a, m), 2, -1, -1);
        end

        @(negedge clk);
        chk("total_err_pulses", n_err, 1);
        chk("total_drop_pulses", n_drop, 1);
`ifdef BIN_POOL_FRAMER_STATS_EN
        chk("final_frame_cnt", frame_cnt, exp_frames);
        chk("final_drop_cnt", drop_cnt, exp_drops);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
